ls_sched: RTL and testbench
===========================

LS_SCHED -- requirements
Module: ls_sched

Interface
REQ-001 Parameter DEPTH, default 4: number of load/store queue entries; power of two.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 rst_c  in  1  pipeline flush on mispredict, synchronous, active-high.
REQ-005 rdy  in  1  global stall; when low, all state and outputs hold.
REQ-006 en_i  in  1  operand-complete load/store from the reservation station.
REQ-007 A_i / B_i / Imm_i  in  32 each  base, store data, immediate.
REQ-008 OP_i  in  7  opcode: 7'b0000011 load, 7'b0100011 store.
REQ-009 Funct3_i  in  3  access width and sign.
REQ-010 ROB_id_i  in  5  ROB tag of the operation.
REQ-011 full_o  out  1  back-pressure to the reservation station.
REQ-012 commit_i / commit_rob_id_i  in  1 / 5  ROB commit of a store.
REQ-013 st_rdy_o / st_rob_id_o  out  1 / 5  store address and data captured; store may now commit.
REQ-014 mem_req_o / mem_we_o  out  1 / 1  memory request, write.
REQ-015 mem_addr_o / mem_wdata_o  out  32 / 32  address, store data.
REQ-016 mem_size_o  out  2  Funct3[1:0].
REQ-017 mem_done_i / mem_rdata_i  in  1 / 32  access complete, raw read data.
REQ-018 cdb_en_o / cdb_id_ROB_o / cdb_data_o  out  1 / 5 / 32  load result broadcast.

Function
REQ-019 Enqueue on en_i: store addr = A_i+Imm_i (mod 2^32), data B_i, op, funct3, tag at tail; committed=0.
REQ-020 full_o = (count >= DEPTH-1): one-slot slack covers the reservation station's one-cycle en_i lag.
REQ-021 en_i with count==DEPTH: drop the request and leave state unchanged; this is an illegal condition.
REQ-022 Store enqueue at cycle N: st_rdy_o=1 and st_rob_id_o=tag at N+1, for one cycle only.
REQ-023 commit_i: set committed on the valid store entry whose tag equals commit_rob_id_i; no match means no effect.
REQ-024 FSM states: IDLE, WAIT, DROP.
REQ-025 IDLE->WAIT when the head is valid and is either a load or a committed store; mem_req_o rises the next cycle.
REQ-026 Head commit and issue are the same event when commit_i matches the head: the request still starts the cycle after commit.
REQ-027 In WAIT, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o and mem_size_o hold stable until mem_done_i.
REQ-028 mem_done_i at cycle M: pop the head and return to IDLE at M+1; the next request starts no earlier than M+2.
REQ-029 Load done at M: cdb_en_o=1 at M+1 for one cycle, carrying the head tag and the extended data.
REQ-030 Load extension: LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged; the byte/halfword is taken from mem_rdata_i[7:0] / [15:0].
REQ-031 Store done: no CDB output.
REQ-032 Enqueue and pop in the same cycle: count unchanged; pointers wrap modulo DEPTH.
REQ-033 rst_c: discard every uncommitted entry (committed stores form a head prefix); tail = head + committed count.
REQ-034 rst_c in WAIT on a load: go to DROP; in DROP, wait for mem_done_i, then pop nothing, suppress the CDB output, and go to IDLE.
REQ-035 rst_c in WAIT on a committed store: stay in WAIT and complete normally.
REQ-036 rst_c and en_i in the same cycle: the incoming op is discarded.
REQ-037 rst_c also clears st_rdy_o and cdb_en_o the next cycle; pending commit_i in that cycle is still honoured.

Reset
REQ-038 rst: queue empty, FSM=IDLE; every output, including full_o, is 0 the next cycle.
REQ-039 rst overrides rst_c, rdy and all inputs, and also abandons any outstanding memory access.

Verification
REQ-040 Load LW: A=0x100, Imm=4, tag 3; mem_done with rdata 0xDEADBEEF -> mem_addr_o=0x104, we=0; then cdb_en_o=1, id 3, data 0xDEADBEEF.
REQ-041 LB then LBU, each with rdata 0x80 -> CDB data 0xFFFFFF80, then 0x00000080.
REQ-042 Store tag 5: st_rdy_o pulses with id 5; no mem_req_o until commit_i id 5; after commit, mem_we_o=1 with data B_i; no CDB output.
REQ-043 Enqueue 3 ops -> full_o=1; enqueue a 4th, which is accepted; a 5th en_i is dropped; pop one -> full_o stays 1 while count>=3.
REQ-044 Load in WAIT, then rst_c -> DROP; mem_done_i -> no cdb_en_o; queue empty; a new load after that issues normally.
REQ-045 Committed store at head plus 2 uncommitted loads, then rst_c -> only the store remains, issues, and count reaches 0.

Source files
------------

// File: rtl/ls_sched.sv
// Load/store queue scheduler: in-order issue of loads and committed stores to a
// single-outstanding memory port, with mispredict flush and load-result broadcast.
module ls_sched #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rst_c,
    input  logic        rdy,
    input  logic        en_i,
    input  logic [31:0] A_i,
    input  logic [31:0] B_i,
    input  logic [31:0] Imm_i,
    input  logic [6:0]  OP_i,
    input  logic [2:0]  Funct3_i,
    input  logic [4:0]  ROB_id_i,
    output logic        full_o,
    input  logic        commit_i,
    input  logic [4:0]  commit_rob_id_i,
    output logic        st_rdy_o,
    output logic [4:0]  st_rob_id_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [1:0]  mem_size_o,
    input  logic        mem_done_i,
    input  logic [31:0] mem_rdata_i,
    output logic        cdb_en_o,
    output logic [4:0]  cdb_id_ROB_o,
    output logic [31:0] cdb_data_o
);

    // state | meaning
    // IDLE  | no access outstanding; issue head when it is a load or a committed store
    // WAIT  | access for the head entry outstanding; memory outputs held
    // DROP  | flushed load still outstanding; absorb its completion, no pop, no CDB
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [6:0]    OP_STORE = 7'b0100011;
    localparam logic [CW-1:0] FULL_TH  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CAP      = CW'(DEPTH);

    state_t          state;
    logic [31:0]     q_addr [DEPTH];
    logic [31:0]     q_data [DEPTH];
    logic [2:0]      q_f3   [DEPTH];
    logic [4:0]      q_tag  [DEPTH];
    logic [DEPTH-1:0] q_valid;
    logic [DEPTH-1:0] q_store;
    logic [DEPTH-1:0] q_cmt;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;

    logic [DEPTH-1:0] cmt_next;
    logic [CW-1:0]   ccnt;
    logic            head_ok;
    logic            do_enq;
    logic            do_pop;

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b100:  return {24'h0, raw[7:0]};
            3'b101:  return {16'h0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    // Commit is folded in before the flush count so a same-cycle commit survives rst_c.
    always_comb begin
        cmt_next = q_cmt;
        ccnt     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (commit_i && q_valid[i] && q_store[i] && (q_tag[i] == commit_rob_id_i))
                cmt_next[i] = 1'b1;
            if (q_valid[i] && cmt_next[i])
                ccnt = ccnt + CW'(1);
        end
    end

    assign head_ok = q_valid[head] && (!q_store[head] || q_cmt[head]);
    assign do_enq  = en_i && !rst_c && (count != CAP);
    assign do_pop  = (state == S_WAIT) && mem_done_i && (q_store[head] || !rst_c);
    assign full_o  = (count >= FULL_TH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            q_valid      <= '0;
            q_store      <= '0;
            q_cmt        <= '0;
            st_rdy_o     <= 1'b0;
            st_rob_id_o  <= '0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            mem_size_o   <= '0;
            cdb_en_o     <= 1'b0;
            cdb_id_ROB_o <= '0;
            cdb_data_o   <= '0;
        end else if (rdy) begin
            st_rdy_o <= 1'b0;
            cdb_en_o <= 1'b0;
            q_cmt    <= cmt_next;

            if (rst_c) begin
                q_valid <= q_valid & cmt_next;
                tail    <= head + ccnt[PW-1:0];
                count   <= ccnt - CW'(do_pop);
            end else begin
                tail  <= tail + PW'(do_enq);
                count <= count + CW'(do_enq) - CW'(do_pop);
            end

            if (do_enq) begin
                q_addr[tail]  <= A_i + Imm_i;
                q_data[tail]  <= B_i;
                q_f3[tail]    <= Funct3_i;
                q_tag[tail]   <= ROB_id_i;
                q_store[tail] <= (OP_i == OP_STORE);
                q_valid[tail] <= 1'b1;
                q_cmt[tail]   <= 1'b0;
                if (OP_i == OP_STORE) begin
                    st_rdy_o    <= 1'b1;
                    st_rob_id_o <= ROB_id_i;
                end
            end

            if (do_pop) begin
                q_valid[head] <= 1'b0;
                q_cmt[head]   <= 1'b0;
                head          <= head + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (head_ok && !rst_c) begin
                        state       <= S_WAIT;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= q_store[head];
                        mem_addr_o  <= q_addr[head];
                        mem_wdata_o <= q_data[head];
                        mem_size_o  <= q_f3[head][1:0];
                    end
                end
                S_WAIT: begin
                    if (mem_done_i) begin
                        state     <= S_IDLE;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        if (!q_store[head] && !rst_c) begin
                            cdb_en_o     <= 1'b1;
                            cdb_id_ROB_o <= q_tag[head];
                            cdb_data_o   <= load_ext(q_f3[head], mem_rdata_i);
                        end
                    end else if (rst_c && !q_store[head]) begin
                        state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (mem_done_i) begin
                        state     <= S_IDLE;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ls_sched.sv
// Self-checking bench for ls_sched: directed scenarios plus a randomized run
// scored against an in-order queue model of the load/store stream.
module tb_ls_sched;
    localparam int DEPTH = 4;

    logic        clk, rst, rst_c, rdy, en_i;
    logic [31:0] A_i, B_i, Imm_i;
    logic [6:0]  OP_i;
    logic [2:0]  Funct3_i;
    logic [4:0]  ROB_id_i;
    logic        full_o;
    logic        commit_i;
    logic [4:0]  commit_rob_id_i;
    logic        st_rdy_o;
    logic [4:0]  st_rob_id_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [1:0]  mem_size_o;
    logic        mem_done_i;
    logic [31:0] mem_rdata_i;
    logic        cdb_en_o;
    logic [4:0]  cdb_id_ROB_o;
    logic [31:0] cdb_data_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  tag;
    } op_t;

    ls_sched #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rst_c(rst_c), .rdy(rdy), .en_i(en_i),
        .A_i(A_i), .B_i(B_i), .Imm_i(Imm_i), .OP_i(OP_i), .Funct3_i(Funct3_i),
        .ROB_id_i(ROB_id_i), .full_o(full_o), .commit_i(commit_i),
        .commit_rob_id_i(commit_rob_id_i), .st_rdy_o(st_rdy_o), .st_rob_id_o(st_rob_id_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o), .mem_done_i(mem_done_i),
        .mem_rdata_i(mem_rdata_i), .cdb_en_o(cdb_en_o), .cdb_id_ROB_o(cdb_id_ROB_o),
        .cdb_data_o(cdb_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en_i = 0; rst_c = 0; commit_i = 0; commit_rob_id_i = 0; mem_done_i = 0;
        mem_rdata_i = 0; A_i = 0; B_i = 0; Imm_i = 0; OP_i = 0; Funct3_i = 0; ROB_id_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rdy = 1; rst = 1;
        step(); step();
        rst = 0;
    endtask

    task automatic enq(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [4:0] tag);
        en_i = 1; OP_i = st ? 7'b0100011 : 7'b0000011; Funct3_i = f3;
        A_i = a; B_i = b; Imm_i = imm; ROB_id_i = tag;
        step();
        en_i = 0;
    endtask

    task automatic commit(input logic [4:0] tag);
        commit_i = 1; commit_rob_id_i = tag;
        step();
        commit_i = 0;
    endtask

    task automatic wait_req(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (mem_req_o) ok = 1;
            else step();
        end
        if (mem_req_o) ok = 1;
    endtask

    task automatic respond(input logic [31:0] rd);
        mem_done_i = 1; mem_rdata_i = rd;
        step();
        mem_done_i = 0;
    endtask

    // Sign/zero extension from the width rules using plain integer arithmetic.
    function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [31:0] raw);
        longint v, span;
        bit sgn;
        case (f3)
            3'd0:    begin span = 256;           sgn = 1; end
            3'd1:    begin span = 65536;         sgn = 1; end
            3'd4:    begin span = 256;           sgn = 0; end
            3'd5:    begin span = 65536;         sgn = 0; end
            default: begin span = 64'h1_0000_0000; sgn = 0; end
        endcase
        v = longint'(raw) % span;
        if (sgn && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    task automatic test_reset();
        bit ok;
        do_reset();
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %b exp 0", full_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", mem_req_o); end
        enq(0, 3'd2, 32'h40, 0, 0, 5'd1);
        enq(0, 3'd2, 32'h44, 0, 0, 5'd2);
        enq(1, 3'd2, 32'h48, 32'h77, 0, 5'd3);
        wait_req(4, ok);
        rst = 1; en_i = 1; commit_i = 1; commit_rob_id_i = 5'd3; rst_c = 1;
        step();
        rst = 0; en_i = 0; commit_i = 0; rst_c = 0;
        checks++; if ({full_o, mem_req_o, mem_we_o, st_rdy_o, cdb_en_o} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs: got full/req/we/strdy/cdb %b exp 00000",
                               {full_o, mem_req_o, mem_we_o, st_rdy_o, cdb_en_o}); end
        checks++; if ({mem_addr_o, mem_wdata_o, mem_size_o, st_rob_id_o, cdb_id_ROB_o, cdb_data_o} !== '0) begin
            errors++; $display("FAIL reset_buses: got addr %h wdata %h exp 0", mem_addr_o, mem_wdata_o); end
        respond(32'h1234);
        ok = 0;
        for (int i = 0; i < 5; i++) begin
            if (cdb_en_o || mem_req_o) ok = 1;
            step();
        end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL reset_abandon: got activity %b exp 0", ok); end
    endtask

    task automatic test_lw();
        bit ok;
        do_reset();
        enq(0, 3'b010, 32'h100, 0, 32'h4, 5'd3);
        wait_req(6, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL lw_req: got %b exp 1", ok); end
        checks++; if ({mem_addr_o, mem_we_o, mem_size_o} !== {32'h104, 1'b0, 2'd2}) begin
            errors++; $display("FAIL lw_addr: got %h we %b size %0d exp 104 0 2", mem_addr_o, mem_we_o, mem_size_o); end
        ok = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (!(mem_req_o && mem_addr_o == 32'h104 && !mem_we_o)) ok = 0;
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL lw_hold: got stable %b exp 1", ok); end
        respond(32'hDEADBEEF);
        checks++; if ({cdb_en_o, cdb_id_ROB_o, cdb_data_o} !== {1'b1, 5'd3, 32'hDEADBEEF}) begin
            errors++; $display("FAIL lw_cdb: got en %b id %0d data %h exp 1 3 deadbeef",
                               cdb_en_o, cdb_id_ROB_o, cdb_data_o); end
        step();
        checks++; if (cdb_en_o !== 1'b0) begin errors++; $display("FAIL lw_cdb_pulse: got %b exp 0", cdb_en_o); end
    endtask

    task automatic test_ext();
        logic [2:0]  lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0]  f3;
        logic [31:0] a, imm, rd, exp;
        logic [4:0]  tag;
        bit ok;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            if (i == 0)      begin f3 = 3'd0; rd = 32'h80; end
            else if (i == 1) begin f3 = 3'd4; rd = 32'h80; end
            else begin f3 = lf3[$urandom_range(4, 0)]; rd = $urandom; end
            a = $urandom; imm = $urandom; tag = 5'($urandom);
            exp = (i == 0) ? 32'hFFFFFF80 : (i == 1) ? 32'h00000080 : ref_ext(f3, rd);
            enq(0, f3, a, 0, imm, tag);
            wait_req(6, ok);
            checks++; if ({ok, mem_addr_o, mem_we_o, mem_size_o} !== {1'b1, a + imm, 1'b0, f3[1:0]}) begin
                errors++; $display("FAIL ext_req[%0d]: got ok %b addr %h we %b size %0d exp addr %h size %0d",
                                   i, ok, mem_addr_o, mem_we_o, mem_size_o, a + imm, f3[1:0]); end
            respond(rd);
            checks++; if ({cdb_en_o, cdb_id_ROB_o, cdb_data_o} !== {1'b1, tag, exp}) begin
                errors++; $display("FAIL ext_cdb[%0d]: f3 %0d got en %b id %0d data %h exp id %0d data %h",
                                   i, f3, cdb_en_o, cdb_id_ROB_o, cdb_data_o, tag, exp); end
        end
    endtask

    task automatic test_store();
        logic [31:0] b;
        bit ok, seen;
        do_reset();
        b = $urandom;
        enq(1, 3'd2, 32'h200, b, 32'h8, 5'd5);
        checks++; if ({st_rdy_o, st_rob_id_o} !== {1'b1, 5'd5}) begin
            errors++; $display("FAIL st_rdy: got %b id %0d exp 1 5", st_rdy_o, st_rob_id_o); end
        step();
        checks++; if (st_rdy_o !== 1'b0) begin errors++; $display("FAIL st_rdy_pulse: got %b exp 0", st_rdy_o); end
        commit(5'd6);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_req_o) seen = 1;
            step();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL st_no_issue: got req %b exp 0", seen); end
        commit(5'd5);
        wait_req(4, ok);
        checks++; if ({ok, mem_we_o, mem_wdata_o, mem_addr_o} !== {2'b11, b, 32'h208}) begin
            errors++; $display("FAIL st_issue: got ok %b we %b wdata %h addr %h exp 1 1 %h 208",
                               ok, mem_we_o, mem_wdata_o, mem_addr_o, b); end
        respond(32'hFFFF_FFFF);
        seen = cdb_en_o;
        step();
        seen = seen | cdb_en_o;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL st_no_cdb: got %b exp 0", seen); end
    endtask

    task automatic test_full();
        bit ok;
        do_reset();
        enq(1, 3'd2, 0, 32'h11, 0, 5'd1);
        enq(1, 3'd2, 0, 32'h22, 0, 5'd2);
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL full_at2: got %b exp 0", full_o); end
        enq(1, 3'd2, 0, 32'h33, 0, 5'd3);
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL full_at3: got %b exp 1", full_o); end
        enq(1, 3'd2, 0, 32'h44, 0, 5'd4);
        checks++; if ({st_rdy_o, st_rob_id_o} !== {1'b1, 5'd4}) begin
            errors++; $display("FAIL full_4th: got %b id %0d exp 1 4", st_rdy_o, st_rob_id_o); end
        enq(1, 3'd2, 0, 32'h99, 0, 5'd9);
        checks++; if (st_rdy_o !== 1'b0) begin errors++; $display("FAIL full_drop: got st_rdy %b exp 0", st_rdy_o); end
        for (int k = 1; k <= 4; k++) begin
            commit(5'(k));
            wait_req(4, ok);
            checks++; if ({ok, mem_wdata_o} !== {1'b1, 32'(k * 32'h11)}) begin
                errors++; $display("FAIL full_drain[%0d]: got ok %b wdata %h exp %h", k, ok, mem_wdata_o, k * 32'h11); end
            respond(0);
            checks++; if (full_o !== (k == 1)) begin
                errors++; $display("FAIL full_after_pop[%0d]: got %b exp %b", k, full_o, k == 1); end
        end
        commit(5'd9);
        ok = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_req_o) ok = 1;
            step();
        end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL full_dropped_issue: got %b exp 0", ok); end
    endtask

    task automatic test_stall();
        bit ok;
        do_reset();
        enq(0, 3'd2, 32'h300, 0, 0, 5'd6);
        wait_req(6, ok);
        rdy = 0; mem_done_i = 1; mem_rdata_i = 32'hCAFE_F00D;
        step(); step();
        checks++; if ({cdb_en_o, mem_req_o} !== 2'b01) begin
            errors++; $display("FAIL stall_hold: got cdb %b req %b exp 0 1", cdb_en_o, mem_req_o); end
        rdy = 1;
        step();
        mem_done_i = 0;
        checks++; if ({cdb_en_o, cdb_id_ROB_o, cdb_data_o} !== {1'b1, 5'd6, 32'hCAFE_F00D}) begin
            errors++; $display("FAIL stall_release: got en %b id %0d data %h exp 1 6 cafef00d",
                               cdb_en_o, cdb_id_ROB_o, cdb_data_o); end
    endtask

    task automatic test_flush_drop();
        bit ok, seen;
        do_reset();
        enq(0, 3'd2, 32'h400, 0, 0, 5'd7);
        wait_req(6, ok);
        rst_c = 1; en_i = 1; OP_i = 7'b0000011; ROB_id_i = 5'd8; A_i = 32'h500;
        step();
        rst_c = 0; en_i = 0;
        respond(32'hABCD);
        checks++; if (cdb_en_o !== 1'b0) begin errors++; $display("FAIL drop_cdb: got %b exp 0", cdb_en_o); end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_req_o || cdb_en_o) seen = 1;
            step();
        end
        checks++; if ({seen, full_o} !== 2'b00) begin
            errors++; $display("FAIL drop_empty: got activity %b full %b exp 0 0", seen, full_o); end
        enq(0, 3'd2, 32'h600, 0, 32'h10, 5'd9);
        wait_req(6, ok);
        checks++; if ({ok, mem_addr_o} !== {1'b1, 32'h610}) begin
            errors++; $display("FAIL drop_next_req: got ok %b addr %h exp 1 610", ok, mem_addr_o); end
        respond(32'h5555);
        checks++; if ({cdb_en_o, cdb_id_ROB_o, cdb_data_o} !== {1'b1, 5'd9, 32'h5555}) begin
            errors++; $display("FAIL drop_next_cdb: got en %b id %0d data %h exp 1 9 5555",
                               cdb_en_o, cdb_id_ROB_o, cdb_data_o); end
    endtask

    task automatic test_flush_store();
        logic [31:0] d;
        bit ok, seen;
        do_reset();
        d = $urandom;
        enq(1, 3'd2, 32'h700, d, 0, 5'd10);
        enq(0, 3'd2, 32'h704, 0, 0, 5'd11);
        enq(0, 3'd2, 32'h708, 0, 0, 5'd12);
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL fst_pre: got req %b exp 0", mem_req_o); end
        commit_i = 1; commit_rob_id_i = 5'd10; rst_c = 1;
        step();
        commit_i = 0; rst_c = 0;
        wait_req(5, ok);
        checks++; if ({ok, mem_we_o, mem_wdata_o, mem_addr_o} !== {2'b11, d, 32'h700}) begin
            errors++; $display("FAIL fst_issue: got ok %b we %b wdata %h addr %h exp 1 1 %h 700",
                               ok, mem_we_o, mem_wdata_o, mem_addr_o, d); end
        respond(0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_req_o || cdb_en_o) seen = 1;
            step();
        end
        checks++; if ({seen, full_o} !== 2'b00) begin
            errors++; $display("FAIL fst_empty: got activity %b full %b exp 0 0", seen, full_o); end
        enq(1, 3'd2, 0, 0, 0, 5'd13);
        enq(1, 3'd2, 0, 0, 0, 5'd14);
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL fst_count: got full %b exp 0", full_o); end
    endtask

    task automatic test_random();
        op_t         ops [$];
        logic [36:0] exp_cdb [$];
        logic [36:0] e;
        logic [2:0]  lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [4:0]  next_tag;
        op_t         o, h;
        bit          req_seen;
        int          dly, nreq;
        do_reset();
        next_tag = 0; req_seen = 0; dly = 0; nreq = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (cdb_en_o) begin
                checks++;
                if (exp_cdb.size() == 0) begin
                    errors++; $display("FAIL rand_cdb_extra: got id %0d data %h exp none", cdb_id_ROB_o, cdb_data_o);
                end else begin
                    e = exp_cdb.pop_front();
                    if ({cdb_id_ROB_o, cdb_data_o} !== e) begin
                        errors++; $display("FAIL rand_cdb: got id %0d data %h exp id %0d data %h",
                                           cdb_id_ROB_o, cdb_data_o, e[36:32], e[31:0]); end
                end
            end
            commit_i = 0;
            if (st_rdy_o) begin commit_i = 1; commit_rob_id_i = st_rob_id_o; end
            mem_done_i = 0;
            if (mem_req_o && !req_seen) begin
                req_seen = 1; dly = $urandom_range(3, 0); nreq++;
                checks++;
                if (ops.size() == 0) begin
                    errors++; $display("FAIL rand_req_extra: got addr %h exp none", mem_addr_o);
                end else begin
                    h = ops[0];
                    if (mem_addr_o !== h.addr || mem_we_o !== h.st || mem_size_o !== h.f3[1:0] ||
                        (h.st && mem_wdata_o !== h.data)) begin
                        errors++; $display("FAIL rand_req: got addr %h we %b size %0d wdata %h exp addr %h we %b size %0d wdata %h",
                                           mem_addr_o, mem_we_o, mem_size_o, mem_wdata_o, h.addr, h.st, h.f3[1:0], h.data); end
                end
            end
            if (req_seen) begin
                if (dly == 0) begin
                    mem_done_i = 1; mem_rdata_i = $urandom; req_seen = 0;
                    if (ops.size() != 0) begin
                        h = ops.pop_front();
                        if (!h.st) exp_cdb.push_back({h.tag, ref_ext(h.f3, mem_rdata_i)});
                    end
                end else begin
                    dly--;
                end
            end
            en_i = 0;
            if (cyc < 350 && !full_o && $urandom_range(1, 0) == 1) begin
                o.st = ($urandom_range(2, 0) == 0);
                o.f3 = o.st ? 3'($urandom_range(2, 0)) : lf3[$urandom_range(4, 0)];
                A_i = $urandom; Imm_i = $urandom; B_i = $urandom;
                o.addr = A_i + Imm_i; o.data = B_i; o.tag = next_tag;
                en_i = 1; OP_i = o.st ? 7'b0100011 : 7'b0000011; Funct3_i = o.f3; ROB_id_i = o.tag;
                ops.push_back(o);
                next_tag = next_tag + 1'b1;
            end
            step();
        end
        en_i = 0; commit_i = 0; mem_done_i = 0;
        checks++; if (ops.size() != 0 || exp_cdb.size() != 0 || nreq == 0) begin
            errors++; $display("FAIL rand_drain: got pending ops %0d cdb %0d reqs %0d exp 0 0 >0",
                               ops.size(), exp_cdb.size(), nreq); end
    endtask

    initial begin
        idle_inputs();
        rdy = 1; rst = 1;
        test_reset();
        test_lw();
        test_ext();
        test_store();
        test_full();
        test_stall();
        test_flush_drop();
        test_flush_store();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
